dct_block_accumulator: RTL and testbench
========================================

Name: dct_block_accumulator

Overview:
- Parametrised N×N 2-D DCT coefficient accumulator with a fixed-point datapath.
- Accepts one block of N*N pixels in raster order over a valid/ready handshake and accumulates every pixel's contribution into all N*N coefficients, held in internal storage.
- Then streams the finished coefficients out.
- Replaces the fixed 4×4 engine that relied on an external coefficient RAM; the basis table is loadable at runtime.

Parameters:
- N, 4, block edge (power of two, 2..8).
- DATA_W, 8, unsigned pixel width.
- COEF_W, 16, signed basis-table entry width, Q1.14.
- ACC_W, 32, signed accumulator/output width, Q.14.

Ports:
- CLK  in  1  clock.
- Reset  in  1  asynchronous active-high reset.
- CE  in  1  clock enable; low freezes all state.
- clear  in  1  synchronous abort; returns to IDLE and zeroes accumulators and counters.
- pix_valid  in  1  pixel offered.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready & CE.
- pix_data  in  DATA_W  unsigned pixel.
- coef_we  in  1  basis-table write strobe.
- coef_addr  in  log2(N*N)  entry n*N+i holds C[n][i].
- coef_wdata  in  COEF_W  signed table value.
- out_valid  out  1  coefficient available.
- out_ready  in  1  downstream accepts.
- out_data  out  ACC_W  coefficient value.
- out_idx  out  log2(N*N)  coefficient index v*N+u.
- out_last  out  1  high with index N*N-1.
- busy  out  1  high whenever state is not IDLE, or pixel count is non-zero.

Behaviour:
- Reset is asynchronous and active-high; one clock, CLK.
- Reset values:
  - State IDLE, pixel count 0, MAC index 0.
  - All accumulators 0.
  - out_valid 0, out_last 0, out_data 0, out_idx 0, pix_ready 0 while Reset is asserted.
  - Basis table: when N==4 it loads the DCT table, row n / column i, as {8192,10703,8192,4433}, {8192,4433,-8192,-10703}, {8192,-4433,-8192,10703}, {8192,-10703,8192,-4433}. Otherwise it loads all zeros.
- CE low: no state or register changes. pix_ready and out_valid are driven 0 (gated combinationally). Table writes are ignored.
- States: IDLE, MAC, OUT.
- IDLE:
  - pix_ready = 1.
  - On accept, latch the pixel and x = cnt mod N, y = cnt div N, then go to MAC with k = 0.
  - coef_we writes take effect only in IDLE with pixel count 0; they are ignored otherwise.
- MAC:
  - pix_ready = 0. One coefficient per enabled cycle, k = 0..N*N-1, u = k mod N, v = k div N.
  - Update: acc[k] += pix × ((C[x][u] × C[y][v]) >>> 14).
    - Full-precision product, arithmetic right shift (floor).
    - pix is zero-extended.
    - Sum wraps modulo 2^ACC_W.
  - After k = N*N-1: if cnt was N*N-1, go to OUT with cnt = 0; otherwise cnt++ and go to IDLE.
  - A pixel accepted at edge t gets its MACs on edges t+1..t+N*N. The earliest next accept is at edge t+N*N+1.
- OUT:
  - out_valid = 1, out_idx = j, out_data = acc[j], out_last = (j == N*N-1).
  - On out_valid & out_ready: clear acc[j] to 0 and set j++.
  - After the last transfer, go to IDLE. The next block starts from clean accumulators.
  - out_data and out_idx hold stable while stalled.
- clear (sampled when CE = 1):
  - Next state is IDLE, cnt = 0, all accumulators = 0, out_valid drops.
  - clear has priority over a simultaneous pixel accept or output transfer; that transfer does not occur.
  - clear does not alter the basis table.
- Reset mid-block or mid-output: immediate return to the reset values.
- Simultaneous coef_we and pixel accept in IDLE (cnt == 0): the write to the table and the pixel latch both happen. The pixel's MACs use the updated table from the next edge onward.

Test Plan:
- Reset, N=4, 16 pixels of 100 with out_ready=1:
  - out_idx 0 → 6553600; out_idx 1 → -800 (per-term floor, row sum -2 ×4 ×100).
  - Exactly 16 outputs, out_last only on idx 15.
- Impulse block, pixel(0,0)=1 and all others 0:
  - out_data[0]=4096, [1]=5351, [5]=6991, [2]=4096.
- Handshake timing, pix_valid held high:
  - Accepts occur every 17 cycles.
  - busy is high from the first accept until the final output transfer.
  - Holding out_ready=0 for 5 cycles in OUT keeps idx/data stable.
- Two consecutive all-100 blocks: the second block's out_idx 0 again reads 6553600, confirming accumulator clear on read.
- clear pulsed during MAC of pixel 7 together with pix_valid:
  - Returns to IDLE; no pixel is accepted that cycle.
  - A following full all-100 block gives idx 0 = 6553600.
- Table write C[0][0]=16384 in IDLE, then the impulse block:
  - idx 0 = 16384.
  - A coef_we issued in MAC or OUT does not change the results.
  - CE low for 3 cycles mid-MAC only delays the results.

Source files
------------

// File: rtl/dct_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : dct_block_accumulator
// Purpose  : N x N 2-D DCT coefficient accumulator. Pixels arrive in raster
//            order over valid/ready; each pixel's contribution is added into
//            all N*N coefficients, which are then streamed out and cleared
//            as they are read. The Q1.14 basis table is writable at runtime.
// Revision : 1.0 - initial release
// ============================================================================
module dct_block_accumulator #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      CE,
  input  logic                      clear,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [DATA_W-1:0]         pix_data,
  input  logic                      coef_we,
  input  logic [$clog2(N*N)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]         coef_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic [$clog2(N*N)-1:0]    out_idx,
  output logic                      out_last,
  output logic                      busy
);

  localparam int NN   = N * N;
  localparam int IW   = $clog2(NN);
  localparam int LW   = $clog2(N);
  localparam int FRAC = 14;
  localparam int PW   = 2 * COEF_W;
  localparam int TW   = DATA_W + 1 + PW;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [IW-1:0]             cnt;      // pixels already accumulated in this block
  logic [IW-1:0]             k;        // MAC coefficient index, reused as output index
  logic [DATA_W-1:0]         pix;
  logic [LW-1:0]             x;
  logic [LW-1:0]             y;
  logic signed [COEF_W-1:0]  tbl [NN];
  logic signed [ACC_W-1:0]   acc [NN];

  logic                      active;
  logic                      accept;
  logic                      xfer;
  logic signed [COEF_W-1:0]  coef_a;
  logic signed [COEF_W-1:0]  coef_b;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      basis;
  logic signed [TW-1:0]      term;
  logic signed [ACC_W-1:0]   mac_sum;

  // Power-on basis table: orthonormal-scaled 4-point DCT, zeros for other sizes
  function automatic logic signed [COEF_W-1:0] init_coef(input int idx);
    int v;
    v = 0;
    if (N == 4) begin
      case (idx)
        0:  v = 8192;   1:  v = 10703;  2:  v = 8192;   3:  v = 4433;
        4:  v = 8192;   5:  v = 4433;   6:  v = -8192;  7:  v = -10703;
        8:  v = 8192;   9:  v = -4433;  10: v = -8192;  11: v = 10703;
        12: v = 8192;   13: v = -10703; 14: v = 8192;   15: v = -4433;
        default: v = 0;
      endcase
    end
    return COEF_W'(v);
  endfunction

  // Handshakes are suppressed while frozen, aborting or in reset so that an
  // advertised ready/valid always means the transfer really happens.
  assign active    = CE & ~clear & ~Reset;
  assign pix_ready = active & (state == IDLE);
  assign out_valid = active & (state == OUT);
  assign accept    = pix_valid & pix_ready;
  assign xfer      = out_valid & out_ready;

  assign out_data  = (state == OUT) ? acc[k] : '0;
  assign out_idx   = (state == OUT) ? k : '0;
  assign out_last  = (state == OUT) && (k == LAST);
  assign busy      = (state != IDLE) || (cnt != '0);

  // Basis products: C[x][u] * C[y][v] floored back to Q.14, then scaled by the
  // zero-extended pixel. All widths are sized so nothing overflows before the
  // final wrap into the accumulator.
  assign coef_a  = tbl[{x, k[LW-1:0]}];
  assign coef_b  = tbl[{y, k[IW-1:LW]}];
  assign prod    = PW'(coef_a) * PW'(coef_b);
  assign basis   = prod >>> FRAC;
  assign term    = TW'($signed({1'b0, pix})) * TW'(basis);
  assign mac_sum = acc[k] + ACC_W'(term);

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; every transition requires CE, and clear overrides all
  always_comb begin
    state_next = state;
    if (CE) begin
      if (clear) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE: if (accept) state_next = MAC;
          MAC:  if (k == LAST) state_next = (cnt == LAST) ? OUT : IDLE;
          OUT:  if (xfer && (k == LAST)) state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // Basis table: writable only between blocks (IDLE with no pixels pending)
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NN; i++) tbl[i] <= init_coef(i);
    end else if (CE && coef_we && (state == IDLE) && (cnt == '0)) begin
      tbl[coef_addr] <= coef_wdata;
    end
  end

  // Pixel latch, MAC/output index, pixel counter and accumulator array
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pix <= '0;
      x   <= '0;
      y   <= '0;
      k   <= '0;
      cnt <= '0;
      for (int i = 0; i < NN; i++) acc[i] <= '0;
    end else if (CE) begin
      if (clear) begin
        k   <= '0;
        cnt <= '0;
        for (int i = 0; i < NN; i++) acc[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              pix <= pix_data;
              x   <= cnt[LW-1:0];
              y   <= cnt[IW-1:LW];
              k   <= '0;
            end
          end
          MAC: begin
            acc[k] <= mac_sum;
            k      <= k + IW'(1);
            // Counter wraps to zero after the last pixel of the block
            if (k == LAST) cnt <= cnt + IW'(1);
          end
          OUT: begin
            if (xfer) begin
              acc[k] <= '0;
              k      <= k + IW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_block_accumulator
// Purpose  : Self-checking bench for dct_block_accumulator (N=4) against a
//            direct sum-of-products model of the 2-D DCT accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct_block_accumulator;

  localparam int N  = 4;
  localparam int NN = 16;

  logic        clk = 1'b0;
  logic        rst, ce, clear, pix_valid, coef_we, out_ready;
  logic [7:0]  pix_data;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  wire         pix_ready, out_valid, out_last, busy;
  wire  [31:0] out_data;
  wire  [3:0]  out_idx;

  int checks = 0;
  int errors = 0;

  int tbl_m [NN];
  int pix_m [NN];
  int exp_m [NN];
  int got_data [64];
  int got_idx  [64];
  bit got_last [64];

  dct_block_accumulator #(.N(N), .DATA_W(8), .COEF_W(16), .ACC_W(32)) dut (
    .CLK(clk), .Reset(rst), .CE(ce), .clear(clear),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic void model_reset_table();
    int d [16] = '{8192, 10703, 8192, 4433, 8192, 4433, -8192, -10703,
                   8192, -4433, -8192, 10703, 8192, -10703, 8192, -4433};
    for (int i = 0; i < NN; i++) tbl_m[i] = d[i];
  endfunction

  // F[v][u] = sum over pixels (x,y) of p(x,y) * floor(C[x][u]*C[y][v] / 2^14)
  function automatic void compute_expected();
    longint s, b;
    for (int v = 0; v < N; v++)
      for (int u = 0; u < N; u++) begin
        s = 0;
        for (int y = 0; y < N; y++)
          for (int x = 0; x < N; x++) begin
            b = (longint'(tbl_m[x*N+u]) * longint'(tbl_m[y*N+v])) >>> 14;
            s = s + longint'(pix_m[y*N+x]) * b;
          end
        exp_m[v*N+u] = int'(s);
      end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_pixel(input logic [7:0] p, output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = p;
    while (!ok && t < 200) begin
      if (pix_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    #1 pix_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input bit gaps, output int n_ok);
    bit ok;
    n_ok = 0;
    for (int i = first; i <= last; i++) begin
      if (gaps) repeat ($urandom_range(2)) @(negedge clk);
      send_pixel(8'(pix_m[i]), ok);
      if (ok) n_ok++;
    end
  endtask

  task automatic collect(input int ready_pct, output int n);
    int t;
    bit done;
    n = 0;
    t = 0;
    done = 1'b0;
    while (!done && t < 2000 && n < 64) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid === 1'b1 && out_ready) begin
        got_data[n] = int'($signed(out_data));
        got_idx[n]  = int'(out_idx);
        got_last[n] = out_last;
        n++;
        if (out_last === 1'b1) begin
          @(posedge clk);
          done = 1'b1;
        end
      end
      t++;
    end
    #1 out_ready = 1'b0;
  endtask

  task automatic wait_out_valid(output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 500) begin
      @(negedge clk);
      if (out_valid === 1'b1) ok = 1'b1;
      t++;
    end
  endtask

  task automatic write_coef(input int a, input logic [15:0] v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 4'(a);
    coef_wdata = v;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: pix_ready=%b out_valid=%b out_last=%b, expected 0 0 0", pix_ready, out_valid, out_last);
    end
    checks++;
    if (out_data !== 32'd0 || out_idx !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_data=%0d out_idx=%0d busy=%b, expected 0 0 0", out_data, out_idx, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: pix_ready=%b busy=%b, expected 1 0", pix_ready, busy);
    end
    ce = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL ce_gates_ready: pix_ready=%b, expected 0", pix_ready);
    end
    ce = 1'b1;
    #1;
  endtask

  task automatic test_constant_block();
    int n_ok, n;
    for (int i = 0; i < NN; i++) pix_m[i] = 100;
    compute_expected();
    send_range(0, NN-1, 1'b0, n_ok);
    collect(100, n);
    checks++;
    if (n_ok !== NN || n !== NN) begin
      errors++;
      $display("FAIL const_counts: accepted=%0d outputs=%0d, expected 16 16", n_ok, n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_idx[i] !== i || got_data[i] !== exp_m[i] || got_last[i] !== (i == NN-1)) begin
        errors++;
        $display("FAIL const_out[%0d]: idx=%0d data=%0d last=%b, expected idx=%0d data=%0d last=%b",
                 i, got_idx[i], got_data[i], got_last[i], i, exp_m[i], (i == NN-1));
      end
    end
    checks++;
    if (got_data[0] !== 6553600 || got_data[1] !== -800) begin
      errors++;
      $display("FAIL const_dc_ac: idx0=%0d idx1=%0d, expected 6553600 -800", got_data[0], got_data[1]);
    end
  endtask

  task automatic test_impulse();
    int n_ok, n;
    for (int i = 0; i < NN; i++) pix_m[i] = 0;
    pix_m[0] = 1;
    compute_expected();
    send_range(0, NN-1, 1'b1, n_ok);
    collect(60, n);
    checks++;
    if (n !== NN) begin
      errors++;
      $display("FAIL impulse_count: outputs=%0d, expected 16", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_idx[i] !== i || got_data[i] !== exp_m[i]) begin
        errors++;
        $display("FAIL impulse_out[%0d]: idx=%0d data=%0d, expected idx=%0d data=%0d", i, got_idx[i], got_data[i], i, exp_m[i]);
      end
    end
    checks++;
    if (got_data[0] !== 4096 || got_data[1] !== 5351 || got_data[5] !== 6991 || got_data[2] !== 4096) begin
      errors++;
      $display("FAIL impulse_points: [0]=%0d [1]=%0d [5]=%0d [2]=%0d, expected 4096 5351 6991 4096",
               got_data[0], got_data[1], got_data[5], got_data[2]);
    end
  endtask

  task automatic test_handshake_timing();
    int t, na, n;
    int acc_t [NN];
    bit busy_bad, ok;
    for (int i = 0; i < NN; i++) pix_m[i] = 100;
    compute_expected();
    out_ready = 1'b0;
    busy_bad  = 1'b0;
    na = 0;
    t  = 0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = 8'd100;
    while (na < NN && t < 1000) begin
      if (na > 0 && busy !== 1'b1) busy_bad = 1'b1;
      if (pix_ready === 1'b1) begin
        acc_t[na] = t;
        na++;
      end
      if (na < NN) begin
        @(negedge clk);
        t++;
      end
    end
    @(posedge clk);
    #1 pix_valid = 1'b0;
    checks++;
    if (na !== NN) begin
      errors++;
      $display("FAIL hs_accepts: accepts=%0d, expected 16", na);
    end
    for (int i = 1; i < na; i++) begin
      checks++;
      if (acc_t[i] - acc_t[i-1] !== 17) begin
        errors++;
        $display("FAIL hs_spacing[%0d]: gap=%0d cycles, expected 17", i, acc_t[i] - acc_t[i-1]);
      end
    end
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 100) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (out_valid === 1'b1) ok = 1'b1;
      t++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hs_out_valid: out_valid=%b after %0d cycles, expected 1", out_valid, t);
    end
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'd0 || $signed(out_data) !== 6553600) begin
        errors++;
        $display("FAIL hs_stall: valid=%b idx=%0d data=%0d, expected 1 0 6553600", out_valid, out_idx, $signed(out_data));
      end
    end
    collect(100, n);
    @(negedge clk);
    checks++;
    if (busy_bad || busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_busy: dropped_early=%b busy_after=%b, expected 0 0", busy_bad, busy);
    end
    checks++;
    if (n !== NN) begin
      errors++;
      $display("FAIL hs_count: outputs=%0d, expected 16", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_idx[i] !== i || got_data[i] !== exp_m[i]) begin
        errors++;
        $display("FAIL hs_out[%0d]: idx=%0d data=%0d, expected idx=%0d data=%0d", i, got_idx[i], got_data[i], i, exp_m[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_ok, n;
    for (int i = 0; i < NN; i++) pix_m[i] = 100;
    compute_expected();
    for (int b = 0; b < 2; b++) begin
      send_range(0, NN-1, 1'b0, n_ok);
      collect(50, n);
      checks++;
      if (n !== NN || got_data[0] !== 6553600) begin
        errors++;
        $display("FAIL b2b_block%0d: outputs=%0d idx0=%0d, expected 16 6553600", b, n, got_data[0]);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_idx[i] !== i || got_data[i] !== exp_m[i]) begin
          errors++;
          $display("FAIL b2b_out%0d[%0d]: idx=%0d data=%0d, expected idx=%0d data=%0d", b, i, got_idx[i], got_data[i], i, exp_m[i]);
        end
      end
    end
  endtask

  task automatic test_clear();
    int n_ok, n;
    bit ok;
    for (int i = 0; i < NN; i++) pix_m[i] = 100;
    compute_expected();
    send_range(0, 7, 1'b0, n_ok);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'd55;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_mac_ready: pix_ready=%b, expected 0", pix_ready);
    end
    @(posedge clk);
    #1 clear = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_mac_idle: busy=%b pix_ready=%b, expected 0 1", busy, pix_ready);
    end
    clear = 1'b1;
    pix_valid = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_blocks_accept: busy=%b, expected 0", busy);
    end
    for (int r = 0; r < 2; r++) begin
      send_range(0, NN-1, 1'b1, n_ok);
      if (r == 0) begin
        wait_out_valid(ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL clear_out_wait: out_valid=%b, expected 1", out_valid);
        end
        repeat (3) begin
          @(negedge clk);
          out_ready = 1'b1;
          @(posedge clk);
        end
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL clear_out_idle: out_valid=%b busy=%b, expected 0 0", out_valid, busy);
        end
      end else begin
        collect(100, n);
        checks++;
        if (n !== NN || got_data[0] !== 6553600) begin
          errors++;
          $display("FAIL clear_after: outputs=%0d idx0=%0d, expected 16 6553600", n, got_data[0]);
        end
        for (int i = 0; i < n; i++) begin
          checks++;
          if (got_idx[i] !== i || got_data[i] !== exp_m[i]) begin
            errors++;
            $display("FAIL clear_out[%0d]: idx=%0d data=%0d, expected idx=%0d data=%0d", i, got_idx[i], got_data[i], i, exp_m[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random_blocks();
    int n_ok, n, a;
    logic [15:0] w;
    for (int b = 0; b < 3; b++) begin
      repeat (4) begin
        a = $urandom_range(NN-1);
        w = 16'($urandom);
        write_coef(a, w);
        tbl_m[a] = int'($signed(w));
      end
      for (int i = 0; i < NN; i++) pix_m[i] = $urandom_range(255);
      compute_expected();
      send_range(0, NN-1, 1'b1, n_ok);
      collect(60, n);
      checks++;
      if (n !== NN) begin
        errors++;
        $display("FAIL rand_count%0d: outputs=%0d, expected 16", b, n);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_idx[i] !== i || got_data[i] !== exp_m[i]) begin
          errors++;
          $display("FAIL rand_out%0d[%0d]: idx=%0d data=%0d, expected idx=%0d data=%0d", b, i, got_idx[i], got_data[i], i, exp_m[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midblock();
    int n_ok, n;
    for (int i = 0; i < NN; i++) pix_m[i] = $urandom_range(255);
    send_range(0, 4, 1'b0, n_ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0 || out_valid !== 1'b0 || out_idx !== 4'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b pix_ready=%b out_valid=%b idx=%0d data=%0d, expected all 0",
               busy, pix_ready, out_valid, out_idx, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset_table();
    for (int i = 0; i < NN; i++) pix_m[i] = 100;
    compute_expected();
    send_range(0, NN-1, 1'b0, n_ok);
    collect(100, n);
    checks++;
    if (n !== NN || got_data[0] !== 6553600) begin
      errors++;
      $display("FAIL midreset_after: outputs=%0d idx0=%0d, expected 16 6553600", n, got_data[0]);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_idx[i] !== i || got_data[i] !== exp_m[i]) begin
        errors++;
        $display("FAIL midreset_out[%0d]: idx=%0d data=%0d, expected idx=%0d data=%0d", i, got_idx[i], got_data[i], i, exp_m[i]);
      end
    end
  endtask

  task automatic test_table_write();
    int n_ok, n;
    bit ok;
    write_coef(0, 16'd16384);
    tbl_m[0] = 16384;
    for (int step = 0; step < 4; step++) begin
      for (int i = 0; i < NN; i++) pix_m[i] = (step == 2) ? int'($urandom_range(255)) : 0;
      if (step != 2) pix_m[0] = 1;
      if (step == 1) begin
        // table write coincident with the first pixel accept
        tbl_m[1] = -1000;
        compute_expected();
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = 4'd1;
        coef_wdata = 16'hFC18;
        pix_valid = 1'b1;
        pix_data = 8'd1;
        checks++;
        if (pix_ready !== 1'b1) begin
          errors++;
          $display("FAIL tw_coincident_ready: pix_ready=%b, expected 1", pix_ready);
        end
        @(posedge clk);
        #1 coef_we = 1'b0;
        pix_valid = 1'b0;
        send_range(1, NN-1, 1'b0, n_ok);
      end else if (step == 2) begin
        // ignored writes in MAC and OUT, CE freeze mid-MAC and in OUT
        compute_expected();
        send_range(0, 4, 1'b0, n_ok);
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = 4'd0;
        coef_wdata = 16'd123;
        @(posedge clk);
        #1 coef_we = 1'b0;
        @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        send_range(5, NN-1, 1'b1, n_ok);
        wait_out_valid(ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL tw_out_wait: out_valid=%b, expected 1", out_valid);
        end
        coef_we = 1'b1;
        coef_addr = 4'd0;
        coef_wdata = 16'd7;
        @(posedge clk);
        #1 coef_we = 1'b0;
        ce = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL tw_ce_gates_valid: out_valid=%b, expected 0", out_valid);
        end
        @(negedge clk);
        ce = 1'b1;
      end else begin
        compute_expected();
        send_range(0, NN-1, 1'b0, n_ok);
      end
      collect(70, n);
      checks++;
      if (n !== NN) begin
        errors++;
        $display("FAIL tw_count%0d: outputs=%0d, expected 16", step, n);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_idx[i] !== i || got_data[i] !== exp_m[i]) begin
          errors++;
          $display("FAIL tw_out%0d[%0d]: idx=%0d data=%0d, expected idx=%0d data=%0d", step, i, got_idx[i], got_data[i], i, exp_m[i]);
        end
      end
      if (step == 0 || step == 3) begin
        checks++;
        if (got_data[0] !== 16384) begin
          errors++;
          $display("FAIL tw_dc%0d: idx0=%0d, expected 16384", step, got_data[0]);
        end
      end
      if (step == 1) begin
        checks++;
        if (got_data[1] !== -1000) begin
          errors++;
          $display("FAIL tw_coincident: idx1=%0d, expected -1000", got_data[1]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    clear = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    out_ready = 1'b0;
    model_reset_table();
    test_reset();
    test_constant_block();
    test_impulse();
    test_handshake_timing();
    test_back_to_back();
    test_clear();
    test_random_blocks();
    test_reset_midblock();
    test_table_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
